cuckoo_lookup: RTL

Lookup/delete engine for the two-table cuckoo hash store; the read-side counterpart of the insert engine. Accepts one key per request, reads both candidate slots (table 1 at h1, table 2 at h2) in parallel through synchronous read ports, and returns hit/miss, table and slot index. For delete requests, it also clears the matching slot's occupancy bit. Sits between the request source and the table storage owned by the insert side.

---
 rtl/cuckoo_pkg.sv | 9 +
 rtl/cuckoo_hash.sv | 23 ++
 rtl/cuckoo_lookup.sv | 108 ++++++++++
 3 files changed

// File: rtl/cuckoo_pkg.sv
// cuckoo_pkg: shared widths and encodings for the two-table cuckoo hash store
package cuckoo_pkg;
    localparam int KEY_W = 32;
    localparam int DEPTH = 10;
    localparam int IDX_W = $clog2(DEPTH);
    typedef enum logic {OP_LOOKUP = 1'b0, OP_DELETE = 1'b1} op_e;
    typedef enum logic {TBL_1 = 1'b0, TBL_2 = 1'b1} tbl_e;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_CLR, S_RSP} state_e;
endpackage

// File: rtl/cuckoo_hash.sv
// cuckoo_hash: slot hashes shared by the insert and lookup engines
module cuckoo_hash
    import cuckoo_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    output logic [IDX_W-1:0] h1,
    output logic [IDX_W-1:0] h2
);
    localparam logic [KEY_W-1:0] D1    = KEY_W'(DEPTH);
    localparam logic [KEY_W+1:0] D2    = (KEY_W+2)'(DEPTH);
    localparam logic [KEY_W+1:0] THREE = (KEY_W+2)'(3);
    logic [KEY_W+1:0] key3;
    logic [KEY_W-1:0] r1;
    logic [KEY_W+1:0] r2;
    always_comb begin
        // key*3 is kept two bits wider so no product bits are lost
        key3 = {2'b00, key} * THREE;
        r1   = key % D1;
        r2   = key3 % D2;
        h1   = r1[IDX_W-1:0];
        h2   = r2[IDX_W-1:0];
    end
endmodule

// File: rtl/cuckoo_lookup.sv
// cuckoo_lookup: reads both candidate slots for a key, reports hit/miss and clears on delete
module cuckoo_lookup
    import cuckoo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [KEY_W-1:0] req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic             rsp_table,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             t1_rd_en,
    output logic             t2_rd_en,
    output logic [IDX_W-1:0] t1_rd_addr,
    output logic [IDX_W-1:0] t2_rd_addr,
    input  logic [KEY_W-1:0] t1_rd_key,
    input  logic [KEY_W-1:0] t2_rd_key,
    input  logic             t1_rd_occ,
    input  logic             t2_rd_occ,
    output logic             t1_clr_en,
    output logic             t2_clr_en,
    output logic [IDX_W-1:0] t1_clr_addr,
    output logic [IDX_W-1:0] t2_clr_addr
);
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    tbl_e             tbl_q, tbl_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [IDX_W-1:0] h1_q, h1_d, h2_q, h2_d, idx_q, idx_d, h1, h2;
    logic             hit_q, hit_d, m1, m2;

    cuckoo_hash u_hash (.key(req_key), .h1(h1), .h2(h2));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tbl_d   = tbl_q;
        key_d   = key_q;
        h1_d    = h1_q;
        h2_d    = h2_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        m1      = t1_rd_occ && (t1_rd_key == key_q);
        m2      = t2_rd_occ && (t2_rd_key == key_q);
        unique case (state_q)
            S_IDLE: if (req_valid) begin
                key_d   = req_key;
                op_d    = op_e'(req_op);
                h1_d    = h1;
                h2_d    = h2;
                state_d = S_RD;
            end
            S_RD:   state_d = S_CMP;
            S_CMP: begin
                // a duplicate key resolves to table 1
                hit_d   = m1 || m2;
                tbl_d   = (!m1 && m2) ? TBL_2 : TBL_1;
                idx_d   = m1 ? h1_q : (m2 ? h2_q : '0);
                state_d = (op_q == OP_DELETE && (m1 || m2)) ? S_CLR : S_RSP;
            end
            S_CLR:  state_d = S_RSP;
            S_RSP:  state_d = rsp_ready ? S_IDLE : S_RSP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOOKUP;
            tbl_q   <= TBL_1;
            key_q   <= '0;
            h1_q    <= '0;
            h2_q    <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tbl_q   <= tbl_d;
            key_q   <= key_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        req_ready   = state_q == S_IDLE;
        rsp_valid   = state_q == S_RSP;
        rsp_hit     = hit_q;
        rsp_table   = tbl_q;
        rsp_idx     = idx_q;
        t1_rd_en    = state_q == S_RD;
        t2_rd_en    = state_q == S_RD;
        t1_rd_addr  = t1_rd_en ? h1_q : '0;
        t2_rd_addr  = t2_rd_en ? h2_q : '0;
        t1_clr_en   = state_q == S_CLR && tbl_q == TBL_1;
        t2_clr_en   = state_q == S_CLR && tbl_q == TBL_2;
        t1_clr_addr = t1_clr_en ? idx_q : '0;
        t2_clr_addr = t2_clr_en ? idx_q : '0;
    end
endmodule
